// File: rtl/cache_line_wb_fill_ctrl.sv
// cache_line_wb_fill_ctrl
// Miss-side sequencer for one cache line. On an accepted miss it writes the
// victim back to memory when it is valid, dirty and PTC-marked, then fetches
// the missed line, and emits the wb / extract / enable strobes consumed by the
// per-line V/D/PTC state machine. Every output comes straight from a register.

`timescale 1ns/1ps

module cache_line_wb_fill_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 128,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    input  logic              line_V,
    input  logic              line_D,
    input  logic              line_PTC,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_err,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              line_wb,
    output logic              line_extract,
    output logic              line_sw,
    output logic              line_enable,
    output logic [LINE_W-1:0] fill_data,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_WB_UPD,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t            state;
    logic [3:0]        retry;
    logic [3:0]        retry_inc;
    logic [ADDR_W-1:0] miss_addr_q;

    // Stores reach the line FSM from the pipeline, never from this block.
    assign line_sw = 1'b0;

    // Retry count after one more failed attempt, held at the limit.
    assign retry_inc = (retry == RETRY_LIMIT) ? retry : retry + 4'd1;

    // Sequencer: state, memory request and all line strobes in one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            retry        <= 4'd0;
            miss_addr_q  <= '0;
            miss_ready   <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            fill_data    <= '0;
            line_wb      <= 1'b0;
            line_extract <= 1'b0;
            line_enable  <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: state registers take non-blocking assignments only; the
            // defaults below make every strobe a single-cycle pulse unless a
            // branch further down re-asserts it in the same edge.
            line_wb      <= 1'b0;
            line_extract <= 1'b0;
            line_enable  <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        miss_ready  <= 1'b0;
                        retry       <= 4'd0;
                        miss_addr_q <= miss_addr;
                        mem_req     <= 1'b1;
                        if (line_V && line_D && line_PTC) begin
                            state     <= S_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= victim_addr;
                            mem_wdata <= victim_data;
                        end else begin
                            state    <= S_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= miss_addr;
                        end
                    end
                end

                S_WB, S_FILL: begin
                    if (!mem_req) begin
                        // Gap cycle after a failed attempt: reissue.
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_err) begin
                            retry <= retry_inc;
                            if (retry_inc == RETRY_LIMIT) begin
                                state <= S_ERR;
                                error <= 1'b1;
                            end
                        end else if (state == S_WB) begin
                            state       <= S_WB_UPD;
                            line_wb     <= 1'b1;
                            line_enable <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            fill_data    <= mem_rdata;
                            done         <= 1'b1;
                            line_extract <= 1'b1;
                            line_enable  <= 1'b1;
                        end
                    end
                end

                S_WB_UPD: begin
                    state    <= S_FILL;
                    retry    <= 4'd0;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= miss_addr_q;
                end

                S_DONE, S_ERR: begin
                    state      <= S_IDLE;
                    miss_ready <= 1'b1;
                    mem_we     <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    miss_ready <= 1'b1;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_wb_fill_ctrl.sv
// Self-checking bench for cache_line_wb_fill_ctrl. A transaction-level model
// expands each miss (victim bits plus a per-attempt ack delay/error schedule)
// into the output waveform required cycle by cycle; one compare process checks
// the DUT against it on every negative clock edge.

`timescale 1ns/1ps

module tb_cache_line_wb_fill_ctrl;

    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 128;
    localparam int MAX_RETRY = 3;

    logic              clk;
    logic              rst_n;
    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic [ADDR_W-1:0] victim_addr;
    logic [LINE_W-1:0] victim_data;
    logic              line_V, line_D, line_PTC;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack, mem_err;
    logic [LINE_W-1:0] mem_rdata;
    logic              line_wb, line_extract, line_sw, line_enable;
    logic [LINE_W-1:0] fill_data;
    logic              done, error;

    cache_line_wb_fill_ctrl #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .victim_addr(victim_addr), .victim_data(victim_data),
        .line_V(line_V), .line_D(line_D), .line_PTC(line_PTC),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
        .line_wb(line_wb), .line_extract(line_extract), .line_sw(line_sw),
        .line_enable(line_enable), .fill_data(fill_data),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              miss_valid;
        logic [ADDR_W-1:0] miss_addr;
        logic [ADDR_W-1:0] victim_addr;
        logic [LINE_W-1:0] victim_data;
        logic              v, d, p;
        logic              ack, err;
        logic [LINE_W-1:0] rdata;
    } stim_t;

    typedef struct {
        logic              miss_ready, mem_req, mem_we;
        logic [ADDR_W-1:0] mem_addr;
        logic [LINE_W-1:0] mem_wdata;
        logic              wb, ext, en, done, error;
        logic [LINE_W-1:0] fill;
        bit                chk_addr, chk_wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the line most recently delivered by a successful fill.
    logic [LINE_W-1:0] fill_model = '0;

    // Per-attempt response schedule: [0] = writeback, [1] = fill.
    int sched_d[2][16];
    bit sched_e[2][16];
    bit                rdata_ovr_en = 1'b0;
    logic [LINE_W-1:0] rdata_ovr    = '0;

    // Observed-event monitor counters.
    int                cyc = 0;
    int                n_wr, n_rd, n_done, n_err, n_wb, n_ext;
    int                t_acc = 0, t_acc_prev = 0, t_done = 0;
    logic [ADDR_W-1:0] last_wr_addr, last_rd_addr;
    logic [LINE_W-1:0] last_wr_data;
    logic              prev_req = 1'b0;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // vmode: 0 = miss_valid low, 1 = random, 2 = held high.
    function automatic stim_t noise(input int vmode);
        stim_t s;
        s.miss_valid  = (vmode == 2) ? 1'b1 : (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        s.miss_addr   = $urandom;
        s.victim_addr = $urandom;
        s.victim_data = rnd_line();
        s.v           = 1'($urandom_range(0, 1));
        s.d           = 1'($urandom_range(0, 1));
        s.p           = 1'($urandom_range(0, 1));
        s.ack         = 1'b0;
        s.err         = 1'($urandom_range(0, 1));
        s.rdata       = rnd_line();
        return s;
    endfunction

    function automatic exp_t exp_base(input logic ready);
        exp_t e;
        e.miss_ready = ready;
        e.mem_req    = 1'b0;
        e.mem_we     = 1'b0;
        e.mem_addr   = '0;
        e.mem_wdata  = '0;
        e.wb         = 1'b0;
        e.ext        = 1'b0;
        e.en         = 1'b0;
        e.done       = 1'b0;
        e.error      = 1'b0;
        e.fill       = fill_model;
        e.chk_addr   = 1'b0;
        e.chk_wdata  = 1'b0;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        miss_valid  = s.miss_valid;
        miss_addr   = s.miss_addr;
        victim_addr = s.victim_addr;
        victim_data = s.victim_data;
        line_V      = s.v;
        line_D      = s.d;
        line_PTC    = s.p;
        mem_ack     = s.ack;
        mem_err     = s.err;
        mem_rdata   = s.rdata;
    endtask

    // One clock cycle: drive inputs just after the edge, queue what this cycle must show.
    task automatic drive(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

    task automatic sched_clean();
        for (int ph = 0; ph < 2; ph++)
            for (int a = 0; a < 16; a++) begin
                sched_d[ph][a] = 0;
                sched_e[ph][a] = 1'b0;
            end
    endtask

    task automatic sched_random();
        for (int ph = 0; ph < 2; ph++)
            for (int a = 0; a < 16; a++) begin
                sched_d[ph][a] = $urandom_range(0, 3);
                sched_e[ph][a] = ($urandom_range(0, 3) == 0);
            end
    endtask

    // One transfer with up to MAX_RETRY attempts; ok=0 means the abort path was taken.
    task automatic run_phase(input int ph, input int vmode, input logic [ADDR_W-1:0] addr,
                             input logic [LINE_W-1:0] wdata, output bit ok);
        stim_t s;
        exp_t  e;
        ok = 1'b0;
        for (int a = 0; a < MAX_RETRY; a++) begin
            for (int c = 0; c <= sched_d[ph][a]; c++) begin
                s = noise(vmode);
                e = exp_base(1'b0);
                e.mem_req   = 1'b1;
                e.mem_we    = (ph == 0);
                e.mem_addr  = addr;
                e.mem_wdata = wdata;
                e.chk_addr  = 1'b1;
                e.chk_wdata = (ph == 0);
                if (c == sched_d[ph][a]) begin
                    s.ack = 1'b1;
                    s.err = sched_e[ph][a];
                    if (rdata_ovr_en) s.rdata = rdata_ovr;
                end
                drive(s, e);
                if (c == sched_d[ph][a] && !sched_e[ph][a] && ph == 1)
                    fill_model = s.rdata;
            end
            if (!sched_e[ph][a]) begin
                ok = 1'b1;
                return;
            end
            if (a == MAX_RETRY - 1) return;
            // Idle gap before the retried request.
            s = noise(vmode);
            drive(s, exp_base(1'b0));
        end
    endtask

    task automatic run_miss(input int idle_n, input int vmode, input logic v, d, p,
                            input logic [ADDR_W-1:0] maddr, vaddr,
                            input logic [LINE_W-1:0] vdata);
        stim_t s;
        exp_t  e;
        bit    ok;
        bit    needs_wb;
        needs_wb = v & d & p;
        for (int i = 0; i < idle_n; i++) begin
            s = noise(0);
            s.ack = 1'($urandom_range(0, 1));
            drive(s, exp_base(1'b1));
        end
        s = noise(0);
        s.miss_valid  = 1'b1;
        s.miss_addr   = maddr;
        s.victim_addr = vaddr;
        s.victim_data = vdata;
        s.v = v; s.d = d; s.p = p;
        drive(s, exp_base(1'b1));
        ok = 1'b1;
        if (needs_wb) begin
            run_phase(0, vmode, vaddr, vdata, ok);
            if (ok) begin
                s = noise(vmode);
                s.ack = 1'($urandom_range(0, 1));
                e = exp_base(1'b0);
                e.wb = 1'b1;
                e.en = 1'b1;
                drive(s, e);
            end
        end
        if (ok) run_phase(1, vmode, maddr, '0, ok);
        s = noise(vmode);
        s.ack = 1'($urandom_range(0, 1));
        e = exp_base(1'b0);
        if (ok) begin
            e.done = 1'b1;
            e.ext  = 1'b1;
            e.en   = 1'b1;
        end else begin
            e.error = 1'b1;
        end
        drive(s, e);
    endtask

    // One trailing idle cycle, then wait until the monitor has seen it.
    task automatic settle();
        stim_t s;
        s = noise(0);
        drive(s, exp_base(1'b1));
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        n_wr = 0; n_rd = 0; n_done = 0; n_err = 0; n_wb = 0; n_ext = 0;
    endtask

    // Compare process and event monitor, on the edge away from the active one.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("exp_queue_depth", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("miss_ready",   miss_ready,   cur.miss_ready);
                check("mem_req",      mem_req,      cur.mem_req);
                check("line_wb",      line_wb,      cur.wb);
                check("line_extract", line_extract, cur.ext);
                check("line_enable",  line_enable,  cur.en);
                check("done",         done,         cur.done);
                check("error",        error,        cur.error);
                check("fill_data",    fill_data,    cur.fill);
                check("line_sw",      line_sw,      1'b0);
                if (cur.chk_addr) begin
                    check("mem_we",   mem_we,   cur.mem_we);
                    check("mem_addr", mem_addr, cur.mem_addr);
                end
                if (cur.chk_wdata) check("mem_wdata", mem_wdata, cur.mem_wdata);
            end
        end
        if (mem_req && !prev_req) begin
            if (mem_we) begin
                n_wr++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
            end else begin
                n_rd++;
                last_rd_addr = mem_addr;
            end
        end
        prev_req = mem_req;
        if (done) begin
            n_done++;
            t_done = cyc;
        end
        if (error)        n_err++;
        if (line_wb)      n_wb++;
        if (line_extract) n_ext++;
        if (miss_valid && miss_ready) begin
            t_acc_prev = t_acc;
            t_acc      = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    localparam logic [LINE_W-1:0] VDATA_D = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

    initial begin
        apply(noise(0));
        mem_ack = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset values.
        check("rst_miss_ready", miss_ready, 1'b1);
        check("rst_mem_req",    mem_req,    1'b0);
        check("rst_mem_we",     mem_we,     1'b0);
        check("rst_mem_addr",   mem_addr,   '0);
        check("rst_mem_wdata",  mem_wdata,  '0);
        check("rst_strobes",    {line_wb, line_extract, line_enable, done, error}, '0);
        check("rst_fill_data",  fill_data,  '0);
        rst_n = 1'b1;

        // Reset in the middle of a fill that is waiting on its ack.
        @(posedge clk); #1;
        miss_valid = 1'b1; miss_addr = 32'h40; line_V = 1'b1; line_D = 1'b0; line_PTC = 1'b1;
        @(posedge clk); #1;
        miss_valid = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        check("midfill_req_before_reset", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midfill_req_async_drop", mem_req,    1'b0);
        check("midfill_ready_async",    miss_ready, 1'b1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_done", done,         1'b0);
            check("post_reset_no_ext",  line_extract, 1'b0);
            check("post_reset_no_req",  mem_req,      1'b0);
        end
        mem_ack = 1'b0;
        fill_model = '0;

        // Clean miss, read acked after 2 wait cycles with 0xA5.. data.
        sched_clean();
        sched_d[1][0] = 2;
        rdata_ovr_en = 1'b1;
        rdata_ovr    = {16{8'hA5}};
        clr_mon();
        run_miss(1, 0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h900, rnd_line());
        settle();
        rdata_ovr_en = 1'b0;
        check("clean_wr_count",  n_wr,         0);
        check("clean_rd_count",  n_rd,         1);
        check("clean_rd_addr",   last_rd_addr, 32'h100);
        check("clean_fill_a5",   fill_data,    {16{8'hA5}});
        check("clean_done_cnt",  n_done,       1);
        check("clean_ext_cnt",   n_ext,        1);
        check("clean_wb_cnt",    n_wb,         0);

        // Clean miss with immediate ack: done two cycles after the accept cycle.
        sched_clean();
        clr_mon();
        run_miss(0, 0, 1'b1, 1'b0, 1'b1, 32'h140, 32'h0, rnd_line());
        settle();
        check("clean_latency", t_done - t_acc, 2);

        // Dirty miss, immediate acks.
        clr_mon();
        run_miss(0, 1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h200, VDATA_D);
        settle();
        check("dirty_wr_count", n_wr,          1);
        check("dirty_wr_addr",  last_wr_addr,  32'h200);
        check("dirty_wr_data",  last_wr_data,  VDATA_D);
        check("dirty_wb_cnt",   n_wb,          1);
        check("dirty_rd_count", n_rd,          1);
        check("dirty_rd_addr",  last_rd_addr,  32'h300);
        check("dirty_done_cnt", n_done,        1);
        check("dirty_latency",  t_done - t_acc, 4);

        // Two write errors then success.
        sched_clean();
        sched_e[0][0] = 1'b1;
        sched_e[0][1] = 1'b1; sched_d[0][1] = 1;
        sched_d[1][0] = 1;
        clr_mon();
        run_miss(2, 1, 1'b1, 1'b1, 1'b1, 32'h340, 32'h240, rnd_line());
        settle();
        check("wretry_wr_count", n_wr,   3);
        check("wretry_rd_count", n_rd,   1);
        check("wretry_err_cnt",  n_err,  0);
        check("wretry_done_cnt", n_done, 1);

        // Read error on every attempt.
        sched_clean();
        sched_e[1][0] = 1'b1;
        sched_e[1][1] = 1'b1; sched_d[1][1] = 2;
        sched_e[1][2] = 1'b1;
        clr_mon();
        run_miss(0, 1, 1'b1, 1'b0, 1'b0, 32'h380, 32'h280, rnd_line());
        settle();
        check("rabort_rd_count", n_rd,   3);
        check("rabort_wr_count", n_wr,   0);
        check("rabort_err_cnt",  n_err,  1);
        check("rabort_ext_cnt",  n_ext,  0);
        check("rabort_done_cnt", n_done, 0);
        sched_clean();
        clr_mon();
        run_miss(0, 0, 1'b0, 1'b0, 1'b0, 32'h3c0, 32'h2c0, rnd_line());
        settle();
        check("rabort_next_done", n_done, 1);

        // miss_valid held high while busy: next accept is the cycle after done.
        sched_clean();
        run_miss(0, 2, 1'b1, 1'b0, 1'b1, 32'h400, 32'h500, rnd_line());
        run_miss(0, 2, 1'b1, 1'b0, 1'b1, 32'h440, 32'h540, rnd_line());
        settle();
        check("held_valid_accept_gap", t_acc - t_acc_prev, 3);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            sched_random();
            run_miss($urandom_range(0, 3), 1,
                     ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0),
                     $urandom, $urandom, rnd_line());
        end
        settle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_wb_fill_ctrl.md
# cache_line_wb_fill_ctrl

Miss-side sequencer that drives a cache line's V/D/PTC state machine from the memory end. On a miss it inspects the victim line's V/D/PTC bits, writes the victim back to memory over a req/ack handshake if it is dirty, then fetches the missed line. It issues the single-cycle wb, extract and enable strobes the per-line state FSM consumes. It sits between the cache tag/data arrays and the memory port.

## Interface
- ADDR_W, 32, line address width (line-aligned byte address)
- LINE_W, 128, cache line data width
- MAX_RETRY, 3, memory error retries per transfer before abort (1..15)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- miss_valid  in  1  miss request
- miss_ready  out  1  controller idle and accepting
- miss_addr  in  ADDR_W  address of missed line
- victim_addr  in  ADDR_W  address of victim line
- victim_data  in  LINE_W  victim line contents
- line_V, line_D, line_PTC  in  1 each  victim line state bits
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (writeback), 0 = read (fill)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  writeback data
- mem_ack  in  1  transfer complete this cycle
- mem_err  in  1  with mem_ack: transfer failed
- mem_rdata  in  LINE_W  fill data, valid with mem_ack
- line_wb  out  1  writeback strobe to line FSM
- line_extract  out  1  fill/extract strobe to line FSM
- line_sw  out  1  tied 0 (stores come from the pipeline)
- line_enable  out  1  line FSM update enable
- fill_data  out  LINE_W  registered fill line
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle abort pulse

## Operation
- States: IDLE, WB, WB_UPD, FILL, DONE, ERR.
- IDLE: miss_ready=1. On miss_valid, capture miss_addr, victim_addr, victim_data and needs_wb = line_V & line_D & line_PTC. Clear retry count. Go to WB if needs_wb, else FILL.
- WB: mem_req=1, mem_we=1, mem_addr=victim_addr, mem_wdata=captured data.
  - mem_ack & !mem_err -> WB_UPD.
  - mem_ack & mem_err -> increment retry; if retry==MAX_RETRY go ERR, else stay in WB (new request issued the next cycle).
- WB_UPD: line_wb=1, line_enable=1 for exactly one cycle. Clear retry. Go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr=miss_addr.
  - mem_ack & !mem_err -> fill_data<=mem_rdata, go DONE.
  - Error path identical to WB.
- DONE: line_extract=1, line_enable=1, done=1 for one cycle. Go to IDLE.
- ERR: error=1 for one cycle. No line strobes. Go to IDLE. The victim line state is left untouched.
- Strobes line_wb and line_extract are never high in the same cycle. line_enable=0 whenever neither is high.
- miss_valid outside IDLE is ignored (miss_ready=0). Captured operands do not change mid-transaction.
- Retry counter is 4 bits and saturates at MAX_RETRY.

## Timing
- Reset (async, rst_n low): state=IDLE, miss_ready=1. mem_req, mem_we, line_wb, line_extract, line_enable, done, error = 0. fill_data=0. mem_addr and mem_wdata=0. Retry=0.
- All outputs are decoded from registered state and registers. There is no combinational path from mem_ack to mem_req.
- mem_req asserts the cycle after entering WB/FILL and stays high until the cycle mem_ack is sampled high. It drops the following cycle, then reasserts one cycle later on retry, so every retry has one idle gap cycle.
- Clean miss with ack on first request cycle: accept at T0, mem_req (read) T1, ack T1, done T2. Total 3 cycles accept-to-done.
- Dirty miss, both acks immediate: WB request T1, line_wb T2, FILL request T3, done T4.
- mem_ack is ignored outside WB/FILL.
- rst_n low mid-transaction: immediate return to reset values. No strobe completes, and no partial line_wb or line_extract is emitted after reset release.

## Test plan
- Reset mid-FILL with mem_req=1 -> mem_req drops asynchronously, miss_ready=1; no done/line_extract after release.
- Clean miss (V=1, D=0, PTC=1), miss_addr=0x100, ack after 2 cycles with rdata=0xA5..A5 -> no write request, one read to 0x100, fill_data=0xA5..A5, single done with line_extract=1, line_wb never high.
- Dirty miss (V=1, D=1, PTC=1), victim_addr=0x200, miss_addr=0x300 -> write to 0x200 with victim_data, line_wb pulse, then read from 0x300, then done. Strobes in separate cycles.
- Write error twice then success, MAX_RETRY=3 -> three write requests with 1-cycle gaps, then normal fill and done, error never high.
- Read error on every attempt, MAX_RETRY=3 -> exactly three read requests, error pulse, no line_extract, back to IDLE accepting a new miss.
- miss_valid held high during busy -> second miss accepted only in the cycle after done (miss_ready=1).
